fcall_arbiter: RTL

Round-robin arbiter and sequencer sharing one three-operand summing function unit (result = a + b + c) among NREQ requesters. Each requester presents an operand triple with a valid/ready handshake. The block grants one call at a time, runs it through the registered function unit, and returns the result tagged with the requester index. It sits between the function-call clients and the shared evaluation datapath.

---
 rtl/fcall_arbiter_if.sv | 28 ++
 rtl/fcall_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fcall_arbiter_if.sv
// Call/result handshake bundle for fcall_arbiter: per-requester operand triples in,
// tagged results out.
interface fcall_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*W-1:0] req_c;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [W+1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ready;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, req_c, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/fcall_arbiter.sv
// Round-robin arbiter sharing one registered a+b+c unit among NREQ requesters.
// Define FCALL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module fcall_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input logic           clk,
    input logic           rst_n,
    fcall_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [W-1:0]   op_c_q, op_c_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic [W+1:0]   res_data_q, res_data_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic [W+1:0]   sum;

    logic [W-1:0] a_arr [NREQ];
    logic [W-1:0] b_arr [NREQ];
    logic [W-1:0] c_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[i*W +: W];
        assign b_arr[i] = bus.req_b[i*W +: W];
        assign c_arr[i] = bus.req_c[i*W +: W];
    end

`ifdef FCALL_ARB_FIXED_PRIO_EN
    // Scan downwards so the lowest valid index is the last to overwrite.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req_valid[IDW'(i)]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] last_g_q, last_g_d;

    always_comb begin
        int unsigned idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_g_q) + k) % NREQ;
            if (!grant_any && bus.req_valid[IDW'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    assign last_g_d = accept ? grant_idx : last_g_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_g_q <= IDW'(NREQ - 1);
        end else begin
            last_g_q <= last_g_d;
        end
    end
`endif

    assign sum = {2'b00, op_a_q} + {2'b00, op_b_q} + {2'b00, op_c_q};

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_c_d     = op_c_q;
        op_id_d    = op_id_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        accept     = 1'b0;
        unique case (state_q)
            StIdle: accept = grant_any;
            StExec: begin
                res_data_d = sum;
                res_id_d   = op_id_q;
                state_d    = StResp;
            end
            StResp: begin
                if (bus.res_ready) begin
                    accept  = grant_any;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new call can be accepted from IDLE or while the current result drains.
        if (accept) begin
            state_d = StExec;
            op_a_d  = a_arr[grant_idx];
            op_b_d  = b_arr[grant_idx];
            op_c_d  = c_arr[grant_idx];
            op_id_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_c_q     <= '0;
            op_id_q    <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_c_q     <= op_c_d;
            op_id_q    <= op_id_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

    assign bus.req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
    assign bus.res_valid = (state_q == StResp);
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = (state_q != StIdle);
endmodule
